// File: rtl/sb_tx_packet_serializer_pkg.sv
// Shared sideband constants and serializer state encoding (package sb_pkg),
// used by both the header encoder and the TX serializer.
package sb_pkg;

  localparam int SB_PKT_BITS   = 64;
  localparam int SB_HDR_CP_BIT = 62;
  localparam int SB_HDR_DP_BIT = 63;
  localparam int SB_HDR_BITS   = 62;
  localparam int SB_DATA_BITS  = 64;
  localparam int SB_BIT_CNT_W  = 6;
  localparam int SB_GAP_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_GAP_HDR,
    ST_SEND_DATA,
    ST_GAP_DATA
  } sb_tx_state_e;

endpackage

// File: rtl/sb_tx_packet_serializer_if.sv
// Encoder-to-serializer message bus plus serial lane status.
// SB_TX_CLK_GATE_EN adds the clk_gate_en lane qualifier.
interface sb_tx_packet_serializer_if;
  import sb_pkg::*;

  logic [SB_HDR_BITS-1:0]  header;
  logic                    header_valid;
  logic [SB_DATA_BITS-1:0] data;
  logic                    data_valid;
  logic                    tx_data;
  logic                    busy;
  logic                    packet_done;
  logic                    overflow;
`ifdef SB_TX_CLK_GATE_EN
  logic                    clk_gate_en;

  modport master (output header, header_valid, data, data_valid,
                  input  tx_data, busy, packet_done, overflow, clk_gate_en);
  modport slave  (input  header, header_valid, data, data_valid,
                  output tx_data, busy, packet_done, overflow, clk_gate_en);
`else
  modport master (output header, header_valid, data, data_valid,
                  input  tx_data, busy, packet_done, overflow);
  modport slave  (input  header, header_valid, data, data_valid,
                  output tx_data, busy, packet_done, overflow);
`endif

endinterface

// File: rtl/sb_tx_packet_serializer_parity_gen.sv
// Completes the 62-bit encoded header with control parity (bit 62) and
// data parity (bit 63); data parity is forced to 0 for header-only messages.
module sb_tx_parity_gen
  import sb_pkg::*;
(
  input  logic [SB_HDR_BITS-1:0]  header,
  input  logic [SB_DATA_BITS-1:0] data,
  input  logic                    data_valid,
  output logic [SB_PKT_BITS-1:0]  word
);

  logic cp;
  logic dp;

  always_comb begin
    cp   = ^header;
    dp   = data_valid & (^data);
    word = '0;
    word[SB_HDR_BITS-1:0] = header;
    word[SB_HDR_CP_BIT]   = cp;
    word[SB_HDR_DP_BIT]   = dp;
  end

endmodule

// File: rtl/sb_tx_packet_serializer.sv
// Sideband TX serializer: header (+ optional data) sent LSB first with an idle
// gap after each 64-bit transfer. Optional macro SB_TX_CLK_GATE_EN adds clk_gate_en.
module sb_tx_packet_serializer
  import sb_pkg::*;
#(
  parameter int GAP_UI = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  sb_tx_packet_serializer_if.slave  bus
);

  localparam logic [SB_GAP_CNT_W-1:0] GAP_LAST = SB_GAP_CNT_W'(GAP_UI - 1);
  localparam logic [SB_BIT_CNT_W-1:0] BIT_LAST = '1;

  sb_tx_state_e state, state_next;

  logic [SB_PKT_BITS-2:0]  shift_reg;
  logic [SB_DATA_BITS-1:0] data_reg;
  logic                    has_data;
  logic [SB_BIT_CNT_W-1:0] bit_cnt;
  logic [SB_GAP_CNT_W-1:0] gap_cnt;
  logic                    tx_data;
  logic                    overflow;

  logic                    pend_vld;
  logic                    pend_dv;
  logic [SB_HDR_BITS-1:0]  pend_hdr;
  logic [SB_DATA_BITS-1:0] pend_data;

  logic                    launch;
  logic                    launch_pend;
  logic                    take_new;
  logic                    bit_last;
  logic                    gap_last;
  logic [SB_HDR_BITS-1:0]  src_hdr;
  logic [SB_DATA_BITS-1:0] src_data;
  logic                    src_dv;
  logic [SB_PKT_BITS-1:0]  src_word;

  // Pending entry always wins the launch; a new message goes to the buffer
  // unless it launches directly from an empty IDLE.
  always_comb begin
    launch_pend = (state == ST_IDLE) && pend_vld;
    launch      = (state == ST_IDLE) && (pend_vld || bus.header_valid);
    take_new    = bus.header_valid && !((state == ST_IDLE) && !pend_vld);
    src_hdr     = pend_vld ? pend_hdr  : bus.header;
    src_data    = pend_vld ? pend_data : bus.data;
    src_dv      = pend_vld ? pend_dv   : bus.data_valid;
    bit_last    = (bit_cnt == BIT_LAST);
    gap_last    = (gap_cnt == GAP_LAST);
  end

  sb_tx_parity_gen u_parity (
    .header     (src_hdr),
    .data       (src_data),
    .data_valid (src_dv),
    .word       (src_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (launch)   state_next = ST_SEND_HDR;
      ST_SEND_HDR:  if (bit_last) state_next = ST_GAP_HDR;
      ST_GAP_HDR:   if (gap_last) state_next = has_data ? ST_SEND_DATA : ST_IDLE;
      ST_SEND_DATA: if (bit_last) state_next = ST_GAP_DATA;
      ST_GAP_DATA:  if (gap_last) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
      data_reg  <= '0;
      has_data  <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_data   <= 1'b0;
      overflow  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_dv   <= 1'b0;
      pend_hdr  <= '0;
      pend_data <= '0;
    end else begin
      // shift_reg holds the bits still to go; tx_data already shows the current one
      if (launch) begin
        tx_data   <= src_word[0];
        shift_reg <= src_word[SB_PKT_BITS-1:1];
        data_reg  <= src_data;
        has_data  <= src_dv;
        bit_cnt   <= '0;
      end else if ((state == ST_GAP_HDR) && gap_last && has_data) begin
        tx_data   <= data_reg[0];
        shift_reg <= data_reg[SB_DATA_BITS-1:1];
        bit_cnt   <= '0;
      end else if (((state == ST_SEND_HDR) || (state == ST_SEND_DATA)) && !bit_last) begin
        tx_data   <= shift_reg[0];
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 6'd1;
      end else begin
        tx_data   <= 1'b0;
        bit_cnt   <= '0;
      end

      if (((state_next == ST_GAP_HDR) || (state_next == ST_GAP_DATA)) &&
          (state_next == state))
        gap_cnt <= gap_cnt + 8'd1;
      else
        gap_cnt <= '0;

      if (take_new) begin
        if (!pend_vld || launch_pend) begin
          pend_vld  <= 1'b1;
          pend_hdr  <= bus.header;
          pend_data <= bus.data;
          pend_dv   <= bus.data_valid;
        end else begin
          overflow  <= 1'b1;
        end
      end else if (launch_pend) begin
        pend_vld <= 1'b0;
      end
    end
  end

  assign bus.tx_data     = tx_data;
  assign bus.busy        = (state != ST_IDLE) || pend_vld;
  assign bus.packet_done = gap_last &&
                           ((state == ST_GAP_DATA) || ((state == ST_GAP_HDR) && !has_data));
  assign bus.overflow    = overflow;

`ifdef SB_TX_CLK_GATE_EN
  logic clk_gate_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) clk_gate_en <= 1'b0;
    else          clk_gate_en <= (state_next == ST_SEND_HDR) || (state_next == ST_SEND_DATA);
  end

  assign bus.clk_gate_en = clk_gate_en;
`endif

endmodule

// File: tb/tb_sb_tx_packet_serializer.sv
// Directed bench for sb_tx_packet_serializer (GAP_UI=32); serial captures are
// compared against hand-computed header/data words.
module tb_sb_tx_packet_serializer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [299:0] cap_tx;
  logic [299:0] cap_busy;
  logic [299:0] cap_done;
  logic [299:0] cap_ovf;
  logic [299:0] cap_cg;
  int           done_first;
  int           done_cnt;

  int           inj_n;
  int           inj_cycle [2];
  logic [61:0]  inj_hdr   [2];
  logic [63:0]  inj_data  [2];
  logic         inj_dv    [2];

  sb_tx_packet_serializer_if bus ();

  sb_tx_packet_serializer #(.GAP_UI(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_msg(input logic [61:0] hdr, input logic [63:0] dat, input logic dv);
    bus.header       = hdr;
    bus.data         = dat;
    bus.data_valid   = dv;
    bus.header_valid = 1'b1;
    tick();
    bus.header_valid = 1'b0;
  endtask

  // Samples n cycles starting now; optional message pulses at chosen cycles.
  task automatic capture(input int n);
    cap_tx = '0; cap_busy = '0; cap_done = '0; cap_ovf = '0; cap_cg = '0;
    for (int i = 0; i < n; i++) begin
      cap_tx[i]   = bus.tx_data;
      cap_busy[i] = bus.busy;
      cap_done[i] = bus.packet_done;
      cap_ovf[i]  = bus.overflow;
`ifdef SB_TX_CLK_GATE_EN
      cap_cg[i]   = bus.clk_gate_en;
`endif
      bus.header_valid = 1'b0;
      for (int k = 0; k < inj_n; k++) begin
        if (i == inj_cycle[k]) begin
          bus.header       = inj_hdr[k];
          bus.data         = inj_data[k];
          bus.data_valid   = inj_dv[k];
          bus.header_valid = 1'b1;
        end
      end
      tick();
    end
    bus.header_valid = 1'b0;
    inj_n      = 0;
    done_first = -1;
    done_cnt   = 0;
    for (int i = 0; i < n; i++) begin
      if (cap_done[i]) begin
        if (done_first < 0) done_first = i;
        done_cnt++;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; inj_n = 0;
    rst_n = 1'b0;
    bus.header = '0; bus.header_valid = 1'b0; bus.data = '0; bus.data_valid = 1'b0;
    repeat (3) tick();

    check("rst_tx",   64'(bus.tx_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.packet_done), 64'd0);
    check("rst_ovf",  64'(bus.overflow), 64'd0);
`ifdef SB_TX_CLK_GATE_EN
    check("rst_cg",   64'(bus.clk_gate_en), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Header-only message; payload present but not flagged, so DP stays 0.
    send_msg(62'h1, 64'h7, 1'b0);
    capture(97);
    check("t1_word",  cap_tx[63:0], 64'h4000_0000_0000_0001);
    check("t1_gap",   64'(cap_tx[96:64]), 64'd0);
    check("t1_done",  64'(done_first), 64'd95);
    check("t1_ndone", 64'(done_cnt), 64'd1);
    check("t1_idle",  64'(bus.busy), 64'd0);

    // Header + data: CP=0, DP=1.
    send_msg(62'h3, 64'h1, 1'b1);
    capture(193);
    check("t2_hdr",   cap_tx[63:0], 64'h8000_0000_0000_0003);
    check("t2_gap1",  64'(cap_tx[95:64]), 64'd0);
    check("t2_data",  cap_tx[159:96], 64'h1);
    check("t2_gap2",  64'(cap_tx[192:160]), 64'd0);
    check("t2_done",  64'(done_first), 64'd191);
    check("t2_busy",  64'({cap_busy[192], cap_busy[191], cap_busy[100]}), 64'b011);
`ifdef SB_TX_CLK_GATE_EN
    check("t2_cg_h",  cap_cg[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_cg_g1", 64'(cap_cg[95:64]), 64'd0);
    check("t2_cg_d",  cap_cg[159:96], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_cg_g2", 64'(cap_cg[192:160]), 64'd0);
`endif

    // Second message mid-packet is buffered and follows after GAP_UI+1 lows.
    send_msg(62'h5, 64'h0, 1'b0);
    inj_n = 1;
    inj_cycle[0] = 10; inj_hdr[0] = 62'h7; inj_data[0] = 64'h0; inj_dv[0] = 1'b0;
    capture(194);
    check("t3_wordA", cap_tx[63:0], 64'h5);
    check("t3_low33", 64'(cap_tx[96:64]), 64'd0);
    check("t3_wordB", cap_tx[160:97], 64'h4000_0000_0000_0007);
    check("t3_ndone", 64'(done_cnt), 64'd2);
    check("t3_ovf",   64'(|cap_ovf[193:0]), 64'd0);
    check("t3_busy_idle", 64'(cap_busy[96]), 64'd1);

    // Three consecutive messages: first launches, second buffered, third dropped.
    send_msg(62'h1, 64'h0, 1'b0);
    inj_n = 2;
    inj_cycle[0] = 0; inj_hdr[0] = 62'h3; inj_data[0] = 64'h0; inj_dv[0] = 1'b0;
    inj_cycle[1] = 1; inj_hdr[1] = 62'hF; inj_data[1] = 64'h0; inj_dv[1] = 1'b0;
    capture(300);
    check("t4_ovf_pre",  64'(cap_ovf[1]), 64'd0);
    check("t4_ovf_set",  64'(cap_ovf[2]), 64'd1);
    check("t4_ovf_stky", 64'(cap_ovf[299]), 64'd1);
    check("t4_word1",    cap_tx[63:0], 64'h4000_0000_0000_0001);
    check("t4_word2",    cap_tx[160:97], 64'h3);
    check("t4_no_third", 64'(|cap_tx[299:193]), 64'd0);
    check("t4_ndone",    64'(done_cnt), 64'd2);

    // Reset at header bit 30 with a message pending.
    send_msg(62'h4000_0001, 64'h0, 1'b0);
    inj_n = 1;
    inj_cycle[0] = 3; inj_hdr[0] = 62'h7; inj_data[0] = 64'h0; inj_dv[0] = 1'b0;
    capture(30);
    check("t5_bit30", 64'(bus.tx_data), 64'd1);
    check("t5_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx",   64'(bus.tx_data), 64'd0);
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_ovf",  64'(bus.overflow), 64'd0);
    rst_n = 1'b1;
    capture(5);
    check("t5_no_resume_tx",   64'(cap_tx[4:0]), 64'd0);
    check("t5_no_resume_busy", 64'(cap_busy[4:0]), 64'd0);

    // Fresh message after reset: CP=1, DP=1.
    send_msg(62'h2, 64'h8000_0000_0000_0003, 1'b1);
    capture(193);
    check("t6_hdr",  cap_tx[63:0], 64'hC000_0000_0000_0002);
    check("t6_data", cap_tx[159:96], 64'h8000_0000_0000_0003);
    check("t6_done", 64'(done_first), 64'd191);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
